// File: rtl/adpll_hop_seq_if.sv
// Channel-request handshake between the host/MAC register block and the hop sequencer.
interface adpll_hop_seq_if #(
  parameter int FCWW = 26
) ();
  logic            req_valid;
  logic            req_ready;
  logic [FCWW-1:0] req_fcw;
  logic [1:0]      req_mode;

  modport master (output req_valid, output req_fcw, output req_mode, input req_ready);
  modport slave  (input req_valid, input req_fcw, input req_mode, output req_ready);
endinterface

// File: rtl/adpll_hop_seq.sv
// ADPLL channel-hop sequencer: parks the ADPLL in PD, launches the new FCW/mode,
// supervises channel_lock with timeout and bounded retry, and reports status.
module adpll_hop_seq #(
  parameter int FCWW      = 26,
  parameter int SETTLE    = 4,
  parameter int BLANK     = 2,
  parameter int LOCK_TMO  = 1024,
  parameter int RETRY_MAX = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  adpll_hop_seq_if.slave     req,
  input  logic               abort,
  input  logic               channel_lock,
  output logic [FCWW-1:0]    FCW,
  output logic [1:0]         adpll_mode,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [1:0]         retry_cnt,
  output logic               lock_lost
);

  localparam logic [1:0] MODE_PD   = 2'd0;
  localparam logic [1:0] MODE_TEST = 2'd1;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_ABT = 2'b10;
  localparam logic [1:0] ST_REJ = 2'b11;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);
  localparam logic [15:0] BLANK_MIN   = 16'(BLANK);
  localparam logic [15:0] TMO_LAST    = 16'(LOCK_TMO - 1);
  localparam logic [1:0]  RETRY_LIM   = 2'(RETRY_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PARK   = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [FCWW-1:0] fcw_q, fcw_d;
  logic [FCWW-1:0] lat_fcw_q, lat_fcw_d;
  logic [1:0]      mode_q, mode_d;
  logic [1:0]      lat_mode_q, lat_mode_d;
  logic [1:0]      retry_q, retry_d;
  logic [1:0]      status_q, status_d;
  logic            done_q, done_d;
  logic            lost_q, lost_d;
  logic            busy_q, busy_d;
  logic            req_ready_s;
  logic            accept_s;

  // Ready only in stable states; abort and reset both block acceptance.
  assign req_ready_s   = ((state_q == S_IDLE) || (state_q == S_LOCKED)) && !abort && !rst;
  assign req.req_ready = req_ready_s;
  assign accept_s      = req.req_valid && req_ready_s && en;

  assign FCW        = fcw_q;
  assign adpll_mode = mode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign retry_cnt  = retry_q;
  assign lock_lost  = lost_q;

  // Next-state and output decode; priority is abort, then acceptance, then lock, then timeout.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fcw_d      = fcw_q;
    lat_fcw_d  = lat_fcw_q;
    mode_d     = mode_q;
    lat_mode_d = lat_mode_q;
    retry_d    = retry_q;
    status_d   = status_q;
    done_d     = 1'b0;
    lost_d     = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      mode_d   = MODE_PD;
      done_d   = 1'b1;
      status_d = ST_ABT;
      state_d  = S_IDLE;
    end else if (accept_s) begin
      case (req.req_mode)
        MODE_PD: begin
          mode_d   = MODE_PD;
          done_d   = 1'b1;
          status_d = ST_OK;
          state_d  = S_IDLE;
        end
        MODE_TEST: begin
          done_d   = 1'b1;
          status_d = ST_REJ;
        end
        default: begin
          lat_fcw_d  = req.req_fcw;
          lat_mode_d = req.req_mode;
          mode_d     = MODE_PD;
          retry_d    = 2'd0;
          timer_d    = SETTLE_LOAD;
          state_d    = S_PARK;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LOCKED: begin
          // Lock drop re-enters supervision without reprogramming the ADPLL.
          if (!channel_lock) begin
            lost_d  = 1'b1;
            timer_d = 16'd0;
            retry_d = 2'd0;
            state_d = S_WAIT;
          end else begin
            state_d = S_LOCKED;
          end
        end
        S_PARK: begin
          if (timer_q == 16'd0) begin
            fcw_d   = lat_fcw_q;
            mode_d  = lat_mode_q;
            timer_d = 16'd0;
            state_d = S_WAIT;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        S_WAIT: begin
          if ((timer_q >= BLANK_MIN) && channel_lock) begin
            done_d   = 1'b1;
            status_d = ST_OK;
            state_d  = S_LOCKED;
          end else if (timer_q == TMO_LAST) begin
            mode_d = MODE_PD;
            if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 2'd1;
              timer_d = SETTLE_LOAD;
              state_d = S_PARK;
            end else begin
              done_d   = 1'b1;
              status_d = ST_TMO;
              state_d  = S_IDLE;
            end
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_PARK) || (state_d == S_WAIT);
  end

  // State and output registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      fcw_q      <= '0;
      lat_fcw_q  <= '0;
      mode_q     <= MODE_PD;
      lat_mode_q <= MODE_PD;
      retry_q    <= 2'd0;
      status_q   <= ST_OK;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fcw_q      <= fcw_d;
      lat_fcw_q  <= lat_fcw_d;
      mode_q     <= mode_d;
      lat_mode_q <= lat_mode_d;
      retry_q    <= retry_d;
      status_q   <= status_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_adpll_hop_seq.sv
// Self-checking bench for adpll_hop_seq: scenario tasks with inline checks plus a
// status scoreboard popped on every done pulse.
module tb_adpll_hop_seq;
  localparam int FCWW      = 26;
  localparam int SETTLE    = 4;
  localparam int BLANK     = 2;
  localparam int LOCK_TMO  = 64;
  localparam int RETRY_MAX = 2;

  localparam logic [1:0] PD = 2'd0, TST = 2'd1, RX = 2'd2, TX = 2'd3;
  localparam logic [1:0] OK = 2'b00, TMO = 2'b01, ABT = 2'b10, REJ = 2'b11;

  logic            clk = 1'b0;
  logic            rst, en, abort, channel_lock;
  logic [FCWW-1:0] FCW;
  logic [1:0]      adpll_mode, status, retry_cnt;
  logic            busy, done, lock_lost;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];

  adpll_hop_seq_if #(.FCWW(FCWW)) hop ();

  adpll_hop_seq #(
    .FCWW(FCWW), .SETTLE(SETTLE), .BLANK(BLANK), .LOCK_TMO(LOCK_TMO), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(hop), .abort(abort), .channel_lock(channel_lock),
    .FCW(FCW), .adpll_mode(adpll_mode), .busy(busy), .done(done), .status(status),
    .retry_cnt(retry_cnt), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest expected status.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got status %0d, want no done", status);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (status !== e) begin
          bad++;
          $display("FAIL sb_status: got %0d want %0d", status, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] mode, input logic [FCWW-1:0] fcw,
                      input bit push, input logic [1:0] st);
    hop.req_valid = 1'b1;
    hop.req_mode  = mode;
    hop.req_fcw   = fcw;
    if (push) exp_q.push_back(st);
    step(1);
    hop.req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      step(1);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    logic [35:0] obs;
    rst = 1'b1; en = 1'b1; abort = 1'b0; channel_lock = 1'b0;
    hop.req_valid = 1'b0; hop.req_mode = PD; hop.req_fcw = '0;
    step(2);
    total++;
    if (hop.req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_in_rst: got %b want 0", hop.req_ready);
    end
    rst = 1'b0;
    #1;
    obs = {FCW, adpll_mode, busy, done, status, retry_cnt, lock_lost, hop.req_ready};
    total++;
    if (obs !== {26'd0, PD, 1'b0, 1'b0, OK, 2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_values: got %h want %h", obs,
                      {26'd0, PD, 1'b0, 1'b0, OK, 2'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int first1 = -1;
    logic [3:0] seen = 4'd0;
    channel_lock = 1'b0;
    send(RX, 26'h0155555, 1'b1, TMO);
    seen[retry_cnt] = 1'b1;
    while (done !== 1'b1 && n < 1000) begin
      step(1);
      n++;
      seen[retry_cnt] = 1'b1;
      if (retry_cnt == 2'd1 && first1 < 0) first1 = n;
    end
    total++;
    if (n !== 3 * (SETTLE + LOCK_TMO)) begin
      bad++; $display("FAIL tmo_latency: got %0d want %0d", n, 3 * (SETTLE + LOCK_TMO));
    end
    total++;
    if (first1 !== SETTLE + LOCK_TMO) begin
      bad++; $display("FAIL tmo_first_retry: got %0d want %0d", first1, SETTLE + LOCK_TMO);
    end
    total++;
    if (seen !== 4'b0111) begin
      bad++; $display("FAIL tmo_retry_seq: got %b want 0111", seen);
    end
    total++;
    if ({adpll_mode, status, retry_cnt, busy, FCW} !== {PD, TMO, 2'd2, 1'b0, 26'h0155555}) begin
      bad++; $display("FAIL tmo_final: got %h want %h", {adpll_mode, status, retry_cnt, busy, FCW},
                      {PD, TMO, 2'd2, 1'b0, 26'h0155555});
    end
  endtask

  task automatic test_lock();
    send(RX, 26'h0A00000, 1'b1, OK);
    total++;
    if ({adpll_mode, busy, FCW} !== {PD, 1'b1, 26'h0155555}) begin
      bad++; $display("FAIL lock_park_entry: got %h want %h", {adpll_mode, busy, FCW}, {PD, 1'b1, 26'h0155555});
    end
    step(3);
    total++;
    if ({adpll_mode, FCW} !== {PD, 26'h0155555}) begin
      bad++; $display("FAIL lock_park_hold: got %h want %h", {adpll_mode, FCW}, {PD, 26'h0155555});
    end
    step(1);
    total++;
    if ({adpll_mode, FCW} !== {RX, 26'h0A00000}) begin
      bad++; $display("FAIL lock_launch: got %h want %h", {adpll_mode, FCW}, {RX, 26'h0A00000});
    end
    step(9);
    total++;
    if ({done, busy} !== 2'b01) begin
      bad++; $display("FAIL lock_waiting: got %b want 01", {done, busy});
    end
    channel_lock = 1'b1;
    step(1);
    total++;
    if ({done, status, busy, retry_cnt} !== {1'b1, OK, 1'b0, 2'd0}) begin
      bad++; $display("FAIL lock_done: got %b want %b", {done, status, busy, retry_cnt}, {1'b1, OK, 1'b0, 2'd0});
    end
  endtask

  task automatic test_lock_lost();
    channel_lock = 1'b0;
    step(1);
    total++;
    if ({lock_lost, busy, done} !== 3'b110) begin
      bad++; $display("FAIL lost_pulse: got %b want 110", {lock_lost, busy, done});
    end
    channel_lock = 1'b1;
    exp_q.push_back(OK);
    step(1);
    total++;
    if ({lock_lost, done} !== 2'b00) begin
      bad++; $display("FAIL lost_one_cycle: got %b want 00", {lock_lost, done});
    end
    step(1);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL lost_blank: got %b want 0", done);
    end
    step(1);
    total++;
    if ({done, status, FCW, adpll_mode} !== {1'b1, OK, 26'h0A00000, RX}) begin
      bad++; $display("FAIL lost_relock: got %h want %h", {done, status, FCW, adpll_mode},
                      {1'b1, OK, 26'h0A00000, RX});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    total++;
    if (hop.req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready_locked: got %b want 1", hop.req_ready);
    end
    send(TX, 26'h1234567, 1'b1, OK);
    wait_done(n);
    total++;
    if (n !== SETTLE + BLANK + 1) begin
      bad++; $display("FAIL b2b_earliest_done: got %0d want %0d", n, SETTLE + BLANK + 1);
    end
    total++;
    if ({FCW, adpll_mode} !== {26'h1234567, TX}) begin
      bad++; $display("FAIL b2b_program: got %h want %h", {FCW, adpll_mode}, {26'h1234567, TX});
    end
  endtask

  task automatic test_cmds();
    int n;
    send(TST, 26'h3FFFFFF, 1'b1, REJ);
    total++;
    if ({done, status, FCW, adpll_mode, busy, hop.req_ready} !== {1'b1, REJ, 26'h1234567, TX, 1'b0, 1'b1}) begin
      bad++; $display("FAIL test_reject: got %h want %h", {done, status, FCW, adpll_mode, busy, hop.req_ready},
                      {1'b1, REJ, 26'h1234567, TX, 1'b0, 1'b1});
    end
    channel_lock = 1'b0;
    step(1);
    total++;
    if (lock_lost !== 1'b1) begin
      bad++; $display("FAIL test_still_locked: got %b want 1", lock_lost);
    end
    channel_lock = 1'b1;
    exp_q.push_back(OK);
    wait_done(n);
    total++;
    if (n !== BLANK + 1) begin
      bad++; $display("FAIL test_relock: got %0d want %0d", n, BLANK + 1);
    end
    send(PD, 26'h2AAAAAA, 1'b1, OK);
    total++;
    if ({done, status, adpll_mode, FCW, busy} !== {1'b1, OK, PD, 26'h1234567, 1'b0}) begin
      bad++; $display("FAIL pd_request: got %h want %h", {done, status, adpll_mode, FCW, busy},
                      {1'b1, OK, PD, 26'h1234567, 1'b0});
    end
    send(RX, 26'h0C00000, 1'b1, OK);
    wait_done(n);
    total++;
    if (n !== SETTLE + BLANK + 1) begin
      bad++; $display("FAIL relaunch: got %0d want %0d", n, SETTLE + BLANK + 1);
    end
    abort = 1'b1;
    hop.req_valid = 1'b1; hop.req_mode = TX; hop.req_fcw = 26'h3000000;
    #1;
    total++;
    if (hop.req_ready !== 1'b0) begin
      bad++; $display("FAIL abort_blocks_ready: got %b want 0", hop.req_ready);
    end
    exp_q.push_back(ABT);
    step(1);
    hop.req_valid = 1'b0; abort = 1'b0;
    total++;
    if ({done, status, adpll_mode, FCW, busy} !== {1'b1, ABT, PD, 26'h0C00000, 1'b0}) begin
      bad++; $display("FAIL abort_wins: got %h want %h", {done, status, adpll_mode, FCW, busy},
                      {1'b1, ABT, PD, 26'h0C00000, 1'b0});
    end
    step(1);
    total++;
    if ({busy, done, hop.req_ready} !== 3'b001) begin
      bad++; $display("FAIL abort_not_accepted: got %b want 001", {busy, done, hop.req_ready});
    end
  endtask

  task automatic test_abort_wait();
    channel_lock = 1'b0;
    send(RX, 26'h0800000, 1'b1, ABT);
    step(SETTLE + 5);
    total++;
    if ({busy, adpll_mode} !== {1'b1, RX}) begin
      bad++; $display("FAIL abortw_in_wait: got %b want %b", {busy, adpll_mode}, {1'b1, RX});
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    total++;
    if ({adpll_mode, done, status, busy} !== {PD, 1'b1, ABT, 1'b0}) begin
      bad++; $display("FAIL abortw_result: got %b want %b", {adpll_mode, done, status, busy}, {PD, 1'b1, ABT, 1'b0});
    end
    step(1);
    total++;
    if ({hop.req_ready, done} !== 2'b10) begin
      bad++; $display("FAIL abortw_ready: got %b want 10", {hop.req_ready, done});
    end
  endtask

  task automatic test_stall_reset();
    int n;
    logic [34:0] obs;
    channel_lock = 1'b1;
    send(RX, 26'h0E00000, 1'b1, OK);
    step(1);
    en = 1'b0;
    step(3);
    total++;
    if ({busy, adpll_mode, done} !== {1'b1, PD, 1'b0}) begin
      bad++; $display("FAIL stall_hold: got %b want %b", {busy, adpll_mode, done}, {1'b1, PD, 1'b0});
    end
    en = 1'b1;
    wait_done(n);
    total++;
    if (n !== SETTLE + BLANK + 1 + 3 - 4) begin
      bad++; $display("FAIL stall_delay: got %0d want %0d", n, SETTLE + BLANK + 1 + 3 - 4);
    end
    abort = 1'b1;
    exp_q.push_back(ABT);
    step(1);
    abort = 1'b0;
    send(TX, 26'h1555555, 1'b0, OK);
    step(1);
    en = 1'b0; rst = 1'b1;
    step(1);
    obs = {FCW, adpll_mode, busy, done, status, retry_cnt, lock_lost};
    total++;
    if (obs !== {26'd0, PD, 1'b0, 1'b0, OK, 2'd0, 1'b0}) begin
      bad++; $display("FAIL rst_mid_park: got %h want %h", obs, {26'd0, PD, 1'b0, 1'b0, OK, 2'd0, 1'b0});
    end
    rst = 1'b0; en = 1'b1;
    #1;
    total++;
    if (hop.req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready: got %b want 1", hop.req_ready);
    end
    step(SETTLE + 2);
    total++;
    if ({busy, done, adpll_mode} !== {1'b0, 1'b0, PD}) begin
      bad++; $display("FAIL rst_idle: got %b want %b", {busy, done, adpll_mode}, {1'b0, 1'b0, PD});
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock();
    test_lock_lost();
    test_back_to_back();
    test_cmds();
    test_abort_wait();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adpll_hop_seq.md
# adpll_hop_seq

Channel-hop sequencer that sits between the host/MAC register interface and the ADPLL controller. It accepts channel requests (FCW + mode) over a valid/ready handshake and parks the ADPLL in power-down so its lock FSM restarts cleanly. It then programs the new FCW and mode, supervises `channel_lock` with a timeout and bounded retry, and reports completion status. It owns the `FCW` and `adpll_mode` inputs of the ADPLL controller; no other block drives them.

## Interface
Parameters:
- `FCWW`, 26, FCW word width (matches `` `FCWW ``).
- `SETTLE`, 4, cycles `adpll_mode` is held at PD before each launch (1..255).
- `BLANK`, 2, cycles after launch during which `channel_lock` is ignored (0..15).
- `LOCK_TMO`, 1024, cycles allowed for lock per attempt (BLANK+1..65535).
- `RETRY_MAX`, 2, extra attempts after the first timeout (0..3).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge. Reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset; has priority over `en`.
- `en` in 1: clock enable; when 0 all registers hold.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle with `req_valid & req_ready & en`.
- `req_fcw` in FCWW: requested frequency control word.
- `req_mode` in 2: 0=PD, 1=TEST, 2=RX, 3=TX.
- `abort` in 1: cancel current operation and power down.
- `channel_lock` in 1: lock flag from the ADPLL controller.
- `FCW` out FCWW: registered FCW to the ADPLL.
- `adpll_mode` out 2: registered mode to the ADPLL.
- `busy` out 1: high in PARK and WAIT_LOCK.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: valid with `done`, held until the next `done`. 00=locked/ok, 01=timeout, 10=aborted, 11=rejected.
- `retry_cnt` out 2: retries used in the current request.
- `lock_lost` out 1: one-cycle pulse when lock drops in LOCKED.

## Operation
- States are IDLE, PARK, WAIT_LOCK and LOCKED.
- `req_ready` = (state==IDLE or LOCKED) & ~abort & ~rst. The request is latched at acceptance.
- Accept with `req_mode`=PD: `adpll_mode`<=PD, `FCW` unchanged, `done` with status 00, go to IDLE.
- Accept with `req_mode`=TEST: `done` with status 11, outputs and state unchanged (TEST is driven only by the test registers).
- Accept with `req_mode`=RX/TX:
  - `adpll_mode`<=PD, `retry_cnt`<=0, load timer with SETTLE-1, go to PARK.
- PARK: timer decrements each cycle. At 0: `FCW`<=latched fcw, `adpll_mode`<=latched mode, timer<=0, go to WAIT_LOCK.
- WAIT_LOCK: timer increments each cycle.
  - Lock is recognised when timer>=BLANK and `channel_lock`=1. On lock: `done` with status 00, go to LOCKED.
  - At timer==LOCK_TMO-1 with no lock:
    - If `retry_cnt`<RETRY_MAX: `retry_cnt`++, `adpll_mode`<=PD, reload timer with SETTLE-1, go to PARK.
    - Otherwise: `adpll_mode`<=PD, `done` with status 01, go to IDLE.
- LOCKED: outputs are held.
  - If `channel_lock` falls to 0: `lock_lost` pulse, timer<=0, `retry_cnt`<=0, go to WAIT_LOCK. FCW and mode are not reprogrammed.
  - A new accepted request behaves as it would from IDLE.
- `abort` in PARK, WAIT_LOCK or LOCKED: `adpll_mode`<=PD, `done` with status 10, go to IDLE. `abort` in IDLE is ignored.
- Priorities: rst > abort > lock > timeout. A lock seen on the timeout cycle counts as success.
- Timer is 16 bits unsigned; it never wraps because it is reset at every state entry.

## Timing
- Reset values: state IDLE, `FCW`=0, `adpll_mode`=0 (PD), `busy`=0, `done`=0, `status`=00, `retry_cnt`=0, `lock_lost`=0, timer=0.
- All outputs are registered except `req_ready`, which is combinational from state, `abort` and `rst`.
- RX/TX request accepted at edge 0:
  - `adpll_mode`=PD and `busy`=1 after edge 1.
  - New `FCW`/mode visible after edge SETTLE+1.
  - Earliest `done` is after edge SETTLE+BLANK+2, with `channel_lock` high at edge SETTLE+BLANK+2.
- Single-attempt failure: `done`/status 01 after edge SETTLE+LOCK_TMO+1. Each retry adds SETTLE+LOCK_TMO cycles.
- `channel_lock` is produced on the negedge domain and sampled here on posedge. It needs no synchroniser (same clock), but BLANK must cover the ADPLL controller's one-cycle lock clear after the PD transition.

## Test plan
- SETTLE=4, BLANK=2. Request RX, FCW=0x0A00000. `channel_lock` rises 10 cycles after launch -> `adpll_mode` is PD for 4 cycles, then 2 with FCW=0x0A00000; `done`, status 00 one cycle after lock is sampled; `busy` falls.
- LOCK_TMO=64, RETRY_MAX=2, `channel_lock` held 0 -> three PARK/launch cycles, `retry_cnt` 0→1→2; `done`, status 01 at cycle 3*(4+64)+1; `adpll_mode`=PD.
- `abort` during WAIT_LOCK, cycle 5 -> next edge `adpll_mode`=PD, `done`, status 10, IDLE; `req_ready`=1 the following cycle.
- In LOCKED, `channel_lock` drops for 1 cycle then returns -> `lock_lost` pulse; WAIT_LOCK; relock after BLANK gives `done`, status 00; FCW unchanged.
- Request TEST, then PD, then `abort`+`req_valid` together in LOCKED -> status 11 (no change); then status 00 with mode PD; then abort wins (status 10) and the request is not accepted.
- `rst` asserted mid-PARK with `en`=0 -> all outputs return to reset values on that edge; `en`=0 otherwise freezes the timer (verify `done` is delayed by exactly the stall length).
